// File: rtl/ctrl_pipe_if.sv
// ID-side request and EX/MEM/WB control outputs of the in-order control pipe.
interface ctrl_pipe_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 8
);
  logic             id_valid;
  logic [6:0]       Opcode;
  logic [REG_W-1:0] id_rs1, id_rs2, id_rd;
  logic             flush;
  logic             stall;
  logic             ex_valid, ex_ALUSrc, ex_Auipc, ex_Branch;
  logic [2:0]       ex_ALUOp;
  logic [1:0]       ex_JalType;
  logic [REG_W-1:0] ex_rd;
  logic             mem_valid, mem_MemRead, mem_MemWrite;
  logic [REG_W-1:0] mem_rd;
  logic             wb_valid, wb_RegWrite, wb_MemtoReg;
  logic [REG_W-1:0] wb_rd;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output id_valid, Opcode, id_rs1, id_rs2, id_rd, flush,
    input  stall, ex_valid, ex_ALUSrc, ex_Auipc, ex_Branch, ex_ALUOp, ex_JalType, ex_rd,
           mem_valid, mem_MemRead, mem_MemWrite, mem_rd,
           wb_valid, wb_RegWrite, wb_MemtoReg, wb_rd, illegal, illegal_cnt
  );
  modport slave (
    input  id_valid, Opcode, id_rs1, id_rs2, id_rd, flush,
    output stall, ex_valid, ex_ALUSrc, ex_Auipc, ex_Branch, ex_ALUOp, ex_JalType, ex_rd,
           mem_valid, mem_MemRead, mem_MemWrite, mem_rd,
           wb_valid, wb_RegWrite, wb_MemtoReg, wb_rd, illegal, illegal_cnt
  );
endinterface

// File: rtl/ctrl_pipe.sv
// RV32I-subset control decode in ID with load-use stall, flush squash and
// EX/MEM/WB control pipeline plus a saturating illegal-opcode counter.
module ctrl_pipe #(
  parameter int REG_W    = 5,
  parameter int CNT_W    = 8,
  parameter int EN_AUIPC = 1
) (
  input logic     clk,
  input logic     reset,
  ctrl_pipe_if.slave bus
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic alusrc, auipc, branch, memread, memwrite, regwrite, memtoreg;
    logic [2:0]       aluop;
    logic [1:0]       jal;
    logic [REG_W-1:0] rd;
  } ex_t;
  typedef struct packed {
    logic memread, memwrite, regwrite, memtoreg;
    logic [REG_W-1:0] rd;
  } mem_t;
  typedef struct packed {
    logic regwrite, memtoreg;
    logic [REG_W-1:0] rd;
  } wb_t;

  ex_t              dec, ex_q;
  mem_t             mem_q;
  wb_t              wb_q;
  logic [2:0]       vld_pipe;
  logic             legal, uses_rs1, uses_rs2, stall, take, ill_hit, ill_q;
  logic [CNT_W-1:0] ill_cnt;

  always_comb begin
    dec      = '0;
    legal    = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (bus.Opcode)
      OP_R:    begin legal = 1'b1; dec.aluop = 3'b010; dec.regwrite = 1'b1;
                     uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_I:    begin legal = 1'b1; dec.aluop = 3'b011; dec.alusrc = 1'b1;
                     dec.regwrite = 1'b1; uses_rs1 = 1'b1; end
      OP_LW:   begin legal = 1'b1; dec.aluop = 3'b000; dec.alusrc = 1'b1; dec.memread = 1'b1;
                     dec.memtoreg = 1'b1; dec.regwrite = 1'b1; uses_rs1 = 1'b1; end
      OP_SW:   begin legal = 1'b1; dec.aluop = 3'b000; dec.alusrc = 1'b1; dec.memwrite = 1'b1;
                     uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_BR:   begin legal = 1'b1; dec.aluop = 3'b001; dec.branch = 1'b1;
                     uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_JAL:  begin legal = 1'b1; dec.aluop = 3'b010; dec.jal = 2'b10; dec.regwrite = 1'b1; end
      OP_JALR: begin legal = 1'b1; dec.aluop = 3'b010; dec.jal = 2'b01; dec.alusrc = 1'b1;
                     dec.regwrite = 1'b1; uses_rs1 = 1'b1; end
      OP_LUI:  begin legal = 1'b1; dec.aluop = 3'b100; dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
      OP_AUIPC: if (EN_AUIPC != 0) begin
                 legal = 1'b1; dec.aluop = 3'b100; dec.alusrc = 1'b1; dec.auipc = 1'b1;
                 dec.regwrite = 1'b1;
               end
      default: ;
    endcase
    // x0 writes are architecturally discarded
    if (bus.id_rd == '0) dec.regwrite = 1'b0;
    dec.rd = bus.id_rd;
  end

  assign stall = bus.id_valid & ~bus.flush & vld_pipe[0] & ex_q.memread & (ex_q.rd != '0) &
                 ((uses_rs1 & (ex_q.rd == bus.id_rs1)) | (uses_rs2 & (ex_q.rd == bus.id_rs2)));
  assign take    = bus.id_valid & ~bus.flush & ~stall & legal;
  assign ill_hit = bus.id_valid & ~bus.flush & ~legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      vld_pipe <= '0;
      ill_q    <= 1'b0;
      ill_cnt  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1:0], take};
      ex_q     <= take ? dec : '0;
      mem_q    <= '{memread: ex_q.memread, memwrite: ex_q.memwrite, regwrite: ex_q.regwrite,
                    memtoreg: ex_q.memtoreg, rd: ex_q.rd};
      wb_q     <= '{regwrite: mem_q.regwrite, memtoreg: mem_q.memtoreg, rd: mem_q.rd};
      ill_q    <= ill_hit;
      if (ill_hit && ill_cnt != '1) ill_cnt <= ill_cnt + CNT_W'(1);
    end
  end

  assign bus.stall        = stall;
  assign bus.ex_valid     = vld_pipe[0];
  assign bus.ex_ALUSrc    = ex_q.alusrc;
  assign bus.ex_Auipc     = ex_q.auipc;
  assign bus.ex_Branch    = ex_q.branch;
  assign bus.ex_ALUOp     = ex_q.aluop;
  assign bus.ex_JalType   = ex_q.jal;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.mem_valid    = vld_pipe[1];
  assign bus.mem_MemRead  = mem_q.memread;
  assign bus.mem_MemWrite = mem_q.memwrite;
  assign bus.mem_rd       = mem_q.rd;
  assign bus.wb_valid     = vld_pipe[2];
  assign bus.wb_RegWrite  = wb_q.regwrite;
  assign bus.wb_MemtoReg  = wb_q.memtoreg;
  assign bus.wb_rd        = wb_q.rd;
  assign bus.illegal      = ill_q;
  assign bus.illegal_cnt  = ill_cnt;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: scoreboard of EX/MEM/WB bundles plus directed stall/flush/illegal/reset cases.
module tb_ctrl_pipe;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, BAD = 7'b0000000;

  logic clk = 1'b0, reset = 1'b1;
  int   checks = 0, errors = 0, cyc = 0;

  ctrl_pipe_if #(.REG_W(5), .CNT_W(8)) a ();
  ctrl_pipe_if #(.REG_W(5), .CNT_W(2)) b ();
  ctrl_pipe #(.REG_W(5), .CNT_W(8), .EN_AUIPC(1)) u0 (.clk(clk), .reset(reset), .bus(a));
  ctrl_pipe #(.REG_W(5), .CNT_W(2), .EN_AUIPC(0)) u1 (.clk(clk), .reset(reset), .bus(b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic legal, alusrc, auipc, branch, memread, memwrite, regwrite, memtoreg;
    logic [2:0] aluop;
    logic [1:0] jal;
    logic uses1, uses2;
  } dec_t;
  typedef struct { int tag; logic [15:0] v; } sb_t;
  sb_t exq[$], memq[$], wbq[$];

  // EX-stage model: does EX hold a valid LW, and its rd
  logic       m_lw = 1'b0;
  logic [4:0] m_rd = '0;
  logic [7:0] exp_cnt = '0;

  logic [15:0] ex_obs, mem_obs, wb_obs;
  logic [39:0] a_all;
  logic [33:0] b_all;
  assign ex_obs  = {3'b0, a.ex_ALUSrc, a.ex_Auipc, a.ex_Branch, a.ex_ALUOp, a.ex_JalType, a.ex_rd};
  assign mem_obs = {9'b0, a.mem_MemRead, a.mem_MemWrite, a.mem_rd};
  assign wb_obs  = {9'b0, a.wb_RegWrite, a.wb_MemtoReg, a.wb_rd};
  assign a_all = {a.stall, a.ex_valid, a.ex_ALUSrc, a.ex_Auipc, a.ex_Branch, a.ex_ALUOp, a.ex_JalType,
                  a.ex_rd, a.mem_valid, a.mem_MemRead, a.mem_MemWrite, a.mem_rd, a.wb_valid,
                  a.wb_RegWrite, a.wb_MemtoReg, a.wb_rd, a.illegal, a.illegal_cnt};
  assign b_all = {b.stall, b.ex_valid, b.ex_ALUSrc, b.ex_Auipc, b.ex_Branch, b.ex_ALUOp, b.ex_JalType,
                  b.ex_rd, b.mem_valid, b.mem_MemRead, b.mem_MemWrite, b.mem_rd, b.wb_valid,
                  b.wb_RegWrite, b.wb_MemtoReg, b.wb_rd, b.illegal, b.illegal_cnt};

  // Columns: legal alusrc auipc branch memread memwrite regwrite memtoreg aluop jal uses_rs1 uses_rs2
  function automatic dec_t decode(input logic [6:0] op, input logic [4:0] rd, input bit en_auipc);
    dec_t d;
    case (op)
      R:     d = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 2'b00, 1'b1, 1'b1};
      I:     d = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011, 2'b00, 1'b1, 1'b0};
      LW:    d = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 2'b00, 1'b1, 1'b0};
      SW:    d = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 1'b1, 1'b1};
      BR:    d = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 2'b00, 1'b1, 1'b1};
      JAL:   d = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 2'b10, 1'b0, 1'b0};
      JALR:  d = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 2'b01, 1'b1, 1'b0};
      LUI:   d = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 2'b00, 1'b0, 1'b0};
      AUIPC: d = en_auipc ? '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 2'b00, 1'b0, 1'b0}
                          : '0;
      default: d = '0;
    endcase
    if (rd == 5'd0) d.regwrite = 1'b0;
    return d;
  endfunction

  // Present one instruction on ID, re-presenting while the model predicts a stall
  task automatic issue(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic fl, output int stalls);
    dec_t d;
    logic exp_stall, acc, exp_ill;
    bit   done = 0;
    d = decode(op, rd, 1'b1);
    a.id_valid = 1'b1; a.Opcode = op; a.id_rs1 = rs1; a.id_rs2 = rs2; a.id_rd = rd; a.flush = fl;
    stalls = 0;
    for (int k = 0; k < 4 && !done; k++) begin
      @(negedge clk);
      exp_stall = !fl && m_lw && (m_rd != 5'd0) &&
                  ((d.uses1 && m_rd == rs1) || (d.uses2 && m_rd == rs2));
      checks++;
      if (a.stall !== exp_stall) begin
        errors++; $display("FAIL stall op=%b: got %b want %b", op, a.stall, exp_stall);
      end
      acc     = !fl && !exp_stall && d.legal;
      exp_ill = !fl && !d.legal;
      if (acc) begin
        exq.push_back('{cyc + 1, {3'b0, d.alusrc, d.auipc, d.branch, d.aluop, d.jal, rd}});
        memq.push_back('{cyc + 2, {9'b0, d.memread, d.memwrite, rd}});
        wbq.push_back('{cyc + 3, {9'b0, d.regwrite, d.memtoreg, rd}});
      end
      @(posedge clk); #1;
      m_lw = acc && d.memread;
      m_rd = acc ? rd : 5'd0;
      if (exp_ill && exp_cnt != 8'hff) exp_cnt = exp_cnt + 8'd1;
      checks++;
      if (a.illegal !== exp_ill || a.illegal_cnt !== exp_cnt) begin
        errors++; $display("FAIL illegal op=%b: got %b/%0d want %b/%0d",
                           op, a.illegal, a.illegal_cnt, exp_ill, exp_cnt);
      end
      if (exp_stall) begin
        stalls++;
        checks++;
        if (a.ex_valid !== 1'b0) begin
          errors++; $display("FAIL stall_bubble: ex_valid got %b want 0", a.ex_valid);
        end
      end else done = 1;
    end
    if (!done) begin
      errors++; $display("FAIL stall_bound: op=%b still stalled after 4 cycles", op);
    end
  endtask

  task automatic idle(input int n);
    a.id_valid = 1'b0; a.flush = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      m_lw = 1'b0; m_rd = '0;
      checks++;
      if (a.illegal !== 1'b0) begin
        errors++; $display("FAIL idle_illegal: got %b want 0", a.illegal);
      end
    end
  endtask

  // Scoreboard: each valid stage pops its oldest expectation; tags pin the exact cycle
  always @(negedge clk) if (!reset) begin
    sb_t e;
    checks++;
    if (a.ex_valid) begin
      if (exq.size() == 0) begin errors++; $display("FAIL ex_unexpected: got %h", ex_obs); end
      else begin
        e = exq.pop_front();
        if (e.tag != cyc || ex_obs !== e.v) begin
          errors++; $display("FAIL ex_bundle: got %h@%0d want %h@%0d", ex_obs, cyc, e.v, e.tag);
        end
      end
    end else if (ex_obs !== 16'h0 || (exq.size() != 0 && exq[0].tag <= cyc)) begin
      errors++; $display("FAIL ex_bubble: got %h, pending %0d", ex_obs, exq.size());
    end
    checks++;
    if (a.mem_valid) begin
      if (memq.size() == 0) begin errors++; $display("FAIL mem_unexpected: got %h", mem_obs); end
      else begin
        e = memq.pop_front();
        if (e.tag != cyc || mem_obs !== e.v) begin
          errors++; $display("FAIL mem_bundle: got %h@%0d want %h@%0d", mem_obs, cyc, e.v, e.tag);
        end
      end
    end else if (mem_obs !== 16'h0 || (memq.size() != 0 && memq[0].tag <= cyc)) begin
      errors++; $display("FAIL mem_bubble: got %h, pending %0d", mem_obs, memq.size());
    end
    checks++;
    if (a.wb_valid) begin
      if (wbq.size() == 0) begin errors++; $display("FAIL wb_unexpected: got %h", wb_obs); end
      else begin
        e = wbq.pop_front();
        if (e.tag != cyc || wb_obs !== e.v) begin
          errors++; $display("FAIL wb_bundle: got %h@%0d want %h@%0d", wb_obs, cyc, e.v, e.tag);
        end
      end
    end else if (wb_obs !== 16'h0 || (wbq.size() != 0 && wbq[0].tag <= cyc)) begin
      errors++; $display("FAIL wb_bubble: got %h, pending %0d", wb_obs, wbq.size());
    end
  end

  task automatic test_reset();
    #2;
    checks += 2;
    if (a_all !== '0) begin errors++; $display("FAIL reset_a: got %h want 0", a_all); end
    if (b_all !== '0) begin errors++; $display("FAIL reset_b: got %h want 0", b_all); end
    @(posedge clk); #1;
    checks++;
    if (a_all !== '0) begin errors++; $display("FAIL reset_hold: got %h want 0", a_all); end
    reset = 1'b0;
  endtask

  task automatic test_decode();
    int s;
    issue(R, 5'd1, 5'd2, 5'd3, 1'b0, s);
    issue(I, 5'd1, 5'd0, 5'd4, 1'b0, s);
    issue(LW, 5'd1, 5'd0, 5'd6, 1'b0, s);
    issue(SW, 5'd2, 5'd9, 5'd11, 1'b0, s);
    issue(BR, 5'd3, 5'd4, 5'd12, 1'b0, s);
    issue(JAL, 5'd0, 5'd0, 5'd1, 1'b0, s);
    issue(JALR, 5'd7, 5'd0, 5'd2, 1'b0, s);
    issue(LUI, 5'd0, 5'd0, 5'd8, 1'b0, s);
    issue(AUIPC, 5'd0, 5'd0, 5'd7, 1'b0, s);
    issue(R, 5'd1, 5'd2, 5'd0, 1'b0, s);
    idle(4);
  endtask

  task automatic test_load_use();
    int s;
    issue(LW, 5'd1, 5'd0, 5'd5, 1'b0, s);
    issue(R, 5'd5, 5'd1, 5'd10, 1'b0, s);
    checks++;
    if (s != 1) begin errors++; $display("FAIL load_use_rs1: stalls got %0d want 1", s); end
    issue(LW, 5'd1, 5'd0, 5'd9, 1'b0, s);
    issue(SW, 5'd2, 5'd9, 5'd0, 1'b0, s);
    checks++;
    if (s != 1) begin errors++; $display("FAIL load_use_rs2: stalls got %0d want 1", s); end
    idle(3);
  endtask

  task automatic test_no_stall();
    int s;
    issue(LW, 5'd1, 5'd0, 5'd0, 1'b0, s);
    issue(R, 5'd0, 5'd0, 5'd3, 1'b0, s);
    checks++;
    if (s != 0) begin errors++; $display("FAIL nostall_x0: stalls got %0d want 0", s); end
    issue(LW, 5'd1, 5'd0, 5'd5, 1'b0, s);
    issue(LUI, 5'd5, 5'd5, 5'd5, 1'b0, s);
    checks++;
    if (s != 0) begin errors++; $display("FAIL nostall_lui: stalls got %0d want 0", s); end
    idle(3);
  endtask

  task automatic test_flush();
    int s;
    issue(JAL, 5'd0, 5'd0, 5'd1, 1'b0, s);
    issue(LW, 5'd1, 5'd0, 5'd3, 1'b1, s);
    checks += 2;
    if (a.ex_valid !== 1'b0) begin errors++; $display("FAIL flush_ex: got %b want 0", a.ex_valid); end
    if (a.mem_valid !== 1'b1) begin errors++; $display("FAIL flush_mem: got %b want 1", a.mem_valid); end
    issue(BAD, 5'd0, 5'd0, 5'd0, 1'b1, s);
    checks++;
    if (a.wb_RegWrite !== 1'b1) begin errors++; $display("FAIL flush_wb: got %b want 1", a.wb_RegWrite); end
    idle(3);
  endtask

  task automatic test_illegal();
    int s;
    repeat (3) issue(BAD, 5'd0, 5'd0, 5'd0, 1'b0, s);
    checks++;
    if (a.illegal_cnt !== 8'd3) begin errors++; $display("FAIL ill_cnt3: got %0d want 3", a.illegal_cnt); end
    idle(2);
  endtask

  task automatic test_auipc_off_sat();
    b.id_valid = 1'b1; b.Opcode = AUIPC; b.id_rd = 5'd7; b.id_rs1 = '0; b.id_rs2 = '0; b.flush = 1'b0;
    @(posedge clk); #1;
    checks += 3;
    if (b.illegal !== 1'b1) begin errors++; $display("FAIL auipc_off_ill: got %b want 1", b.illegal); end
    if (b.ex_valid !== 1'b0) begin errors++; $display("FAIL auipc_off_ex: got %b want 0", b.ex_valid); end
    if (b.illegal_cnt !== 2'd1) begin errors++; $display("FAIL auipc_off_cnt: got %0d want 1", b.illegal_cnt); end
    b.Opcode = BAD;
    repeat (4) @(posedge clk);
    #1;
    checks += 2;
    if (b.illegal_cnt !== 2'd3) begin errors++; $display("FAIL cnt_sat: got %0d want 3", b.illegal_cnt); end
    if (b.illegal !== 1'b1) begin errors++; $display("FAIL sat_pulse: got %b want 1", b.illegal); end
    b.id_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (b.illegal !== 1'b0) begin errors++; $display("FAIL b_idle_ill: got %b want 0", b.illegal); end
  endtask

  task automatic test_reset_mid();
    int s;
    issue(SW, 5'd1, 5'd2, 5'd0, 1'b0, s);
    issue(BR, 5'd3, 5'd4, 5'd0, 1'b0, s);
    issue(R, 5'd1, 5'd2, 5'd5, 1'b0, s);
    a.id_valid = 1'b0;
    #1 reset = 1'b1;
    exq.delete(); memq.delete(); wbq.delete();
    m_lw = 1'b0; m_rd = '0; exp_cnt = '0;
    #1;
    checks += 2;
    if (a_all !== '0) begin errors++; $display("FAIL async_reset_a: got %h want 0", a_all); end
    if (b_all !== '0) begin errors++; $display("FAIL async_reset_b: got %h want 0", b_all); end
    @(posedge clk); #1;
    reset = 1'b0;
    issue(R, 5'd1, 5'd2, 5'd4, 1'b0, s);
    idle(4);
  endtask

  initial begin
    a.id_valid = 1'b0; a.Opcode = '0; a.id_rs1 = '0; a.id_rs2 = '0; a.id_rd = '0; a.flush = 1'b0;
    b.id_valid = 1'b0; b.Opcode = '0; b.id_rs1 = '0; b.id_rs2 = '0; b.id_rd = '0; b.flush = 1'b0;
    test_reset();
    test_decode();
    test_load_use();
    test_no_stall();
    test_flush();
    test_illegal();
    test_auipc_off_sat();
    test_reset_mid();
    checks++;
    if (exq.size() + memq.size() + wbq.size() != 0) begin
      errors++; $display("FAIL drain: %0d expected bundles never appeared", exq.size() + memq.size() + wbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
